// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the byte-to-serial CRC-8 path.
package crc_pkg;
  localparam int CRC_W  = 8;
  localparam int DATA_W = 8;

  localparam logic [CRC_W-1:0] DEF_POLY = 8'h07;
  localparam logic [CRC_W-1:0] DEF_SEED = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/crc8_lfsr.sv
// Bit-serial CRC-8 register: feedback mode absorbs din MSB-first, drain mode shifts the remainder out.
module crc8_lfsr
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY,
  parameter logic [CRC_W-1:0] SEED = DEF_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic din,
  input  logic mode,
  output logic msb
);

  logic [CRC_W-1:0] crc;
  logic             fb;

  // Drain mode forces zero feedback so the remainder leaves unchanged.
  assign fb = ~mode & (din ^ crc[CRC_W-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= SEED;
    end else if (load) begin
      crc <= SEED;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  assign msb = crc[CRC_W-1];

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer: accepts bytes on valid/ready, feeds them MSB-first to the CRC-8 LFSR, then drains the CRC serially.
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY,
  parameter logic [CRC_W-1:0] SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              crc_out,
  output logic              crc_valid,
  output logic              done,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] data_sr;
  logic              last_q;
  logic              accept;
  logic              lfsr_msb;

  assign in_ready = (state == IDLE) || (state == WAIT);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd0) state_nxt = last_q ? OUT : WAIT;
      WAIT:    if (accept) state_nxt = SHIFT;
      OUT:     if (bit_cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt wraps 0 -> 7 on the last SHIFT edge, which primes the 8-cycle OUT count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bit_cnt <= 3'd7;
        last_q  <= in_last;
      end else if ((state == SHIFT) || (state == OUT)) begin
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_sr <= in_data;
    end else if (state == SHIFT) begin
      data_sr <= {data_sr[DATA_W-2:0], 1'b0};
    end
  end

  crc8_lfsr #(
    .POLY (POLY),
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept && (state == IDLE)),
    .en   ((state == SHIFT) || (state == OUT)),
    .din  (data_sr[DATA_W-1]),
    .mode (state == OUT),
    .msb  (lfsr_msb)
  );

  assign crc_valid = (state == OUT);
  assign crc_out   = (state == OUT) & lfsr_msb;
  assign done      = (state == OUT) && (bit_cnt == 3'd0);
  assign busy      = (state != IDLE);

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Byte-stream sequencer for the serial CRC-8 engine. Accepts frame bytes over a valid/ready handshake, serializes each byte MSB-first into an LFSR, and on the last byte emits the 8-bit CRC serially with `crc_valid`. It replaces hand-driven `active` sequencing of the bit-level CRC/counter path and sits between the byte-wide frame source and the serial link.

## Interface
- `POLY`, 8'h07: CRC-8 generator polynomial, x^8 term implicit.
- `SEED`, 8'h00: LFSR value loaded at the start of each frame.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: source presents a byte.
- `in_data` input 8: frame byte.
- `in_last` input 1: byte is the final byte of the frame; qualified by `in_valid`.
- `in_ready` output 1: controller can accept a byte this cycle.
- `crc_out` output 1: serial CRC bit, MSB first.
- `crc_valid` output 1: `crc_out` is meaningful.
- `done` output 1: one-cycle pulse on the final CRC bit.
- `busy` output 1: high in any state except IDLE.

## Operation
- States: IDLE, SHIFT, WAIT, OUT.
- **Accept rule:** a byte is accepted when `in_valid & in_ready` at a rising edge.
  - `in_data` and `in_last` are captured into a shift register and a last flag.
  - The source may change them afterwards.
- **IDLE**
  - `in_ready`=1.
  - On accept: LFSR <= SEED, go to SHIFT, bit_cnt <= 7.
- **SHIFT** (8 cycles)
  - `in_ready`=0.
  - Each edge: fb = data_sr[7] ^ crc[7]; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 0); data_sr shifts left.
  - After the bit_cnt==0 edge: go to OUT if the last flag is set, else WAIT.
- **WAIT**
  - `in_ready`=1; LFSR holds.
  - On accept: go to SHIFT with no reseed.
  - An unbounded wait is legal.
- **OUT** (8 cycles)
  - `crc_valid`=1, `crc_out`=crc[7].
  - LFSR shifts left with zero fill each edge.
  - `done`=1 in the 8th cycle; next state IDLE.
- `in_valid` while `in_ready`=0 is ignored. The byte stays pending at the source; it is not dropped.
- **Zero-length frames:** none. Every frame has at least one byte.
- **Outputs:** `crc_out`, `crc_valid`, `done` and `busy` are registered or decoded from registered state only. There is no combinational path from inputs to outputs. `in_ready` depends on state only.

## Timing
- **Reset values (all applied asynchronously):**
  - state IDLE, LFSR = SEED, bit_cnt 0.
  - `crc_valid`=0, `crc_out`=0, `done`=0, `busy`=0, `in_ready`=1.
  - No transfer occurs while `rst`=0.
- **Latency:** accept of the last byte at edge E gives `crc_valid`=1 in the cycles following edges E+8 through E+15.
  - `done` is high in the cycle after edge E+15.
  - `in_ready`=1 again after edge E+16.
- **Throughput:** one byte per 9 cycles minimum (8 SHIFT + 1 accept cycle).
- **Reset mid-frame:** reset asserted in any state aborts immediately.
  - `crc_valid` and `busy` drop without waiting for a clock.
  - The next frame after release starts from SEED.
- **Same-edge events:** an accept in WAIT on the same edge `in_last` rises is treated as the final byte. SHIFT then goes to OUT.

## Structure
- **Package `crc_pkg`:**
  - state encoding constants (IDLE/SHIFT/WAIT/OUT);
  - `CRC_W`=8;
  - default POLY and SEED.
- **Sub-module `crc8_lfsr`:**
  - ports: clk, rst, load (seed), en, din, mode (0 = feedback, 1 = zero-fill drain), msb output.
  - POLY and SEED parameters.
- The controller owns the FSM, bit_cnt, data shift register and handshake.

## Test plan
- **Reset:** hold `rst`=0 with `in_valid`=1 for 3 cycles.
  - Required: `in_ready`=1, `busy`=0, `crc_valid`=0, `done`=0.
  - Required: no accept; after release the first accept is clean.
- **Single byte 0x01, `in_last`=1:**
  - Required: `crc_valid` high 8 cycles, beginning after edge E+8.
  - Required: `crc_out` = 0,0,0,0,0,1,1,1 (0x07); `done` on the 8th bit.
- **Single byte 0x80, `in_last`=1:**
  - Required: serial 1,0,0,0,1,0,0,1 (0x89).
- **Two-byte frame 0x01 then 0x00 (last), `in_valid` gap of 3 cycles:**
  - Required: WAIT holds with `busy`=1 and `in_ready`=1.
  - Required: CRC 0x15.
- **Back-to-back frames:** second frame's 0x01 (last) held on `in_valid` from the first cycle of OUT.
  - Required: not accepted until IDLE.
  - Required: reseeded; second CRC again 0x07.
- **Mid-frame reset:** assert `rst`=0 during the 4th OUT cycle.
  - Required: `crc_valid` and `busy` drop asynchronously.
  - Required: a following 0x80 frame yields 0x89.
